lo_pipe_reg: RTL
================

Name: lo_pipe_reg

Overview:
- Parametrised, elastic successor to the generic enabled register: a chain of DEPTH register stages, each WIDTH bits wide.
- Each stage carries a valid bit. Stages use valid/ready handshakes with per-stage backpressure and bubble collapse, and a synchronous flush.
- Used between processor/datapath pipeline stages (e.g. decode -> execute) where stalls and squashes must be handled locally rather than with a single global enable.

Parameters:
- WIDTH, 32, data width in bits (>=1).
- DEPTH, 2, number of register stages (>=1).
- RESET_VAL, 0, value loaded into every data stage on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous squash of all stage contents.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  pipe accepts in_data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  stage DEPTH-1 holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  data of stage DEPTH-1.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages (registered).

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on rising clk; it has priority over flush and all transfers.
- Reset values: all stage valid bits 0, all data stages RESET_VAL, occupancy 0. As a result, out_valid=0 and out_data=RESET_VAL after reset.
- Stage i has registers v[i], d[i]. Stage 0 is fed from the input; stage DEPTH-1 drives the outputs.
- Ready chain (combinational):
  - r[DEPTH] = out_ready.
  - r[i] = !v[i] | r[i+1].
  - in_ready = r[0] & !flush.
- Stage i loads on a clock edge when r[i]=1:
  - v[i] <= v[i-1], with the source for i=0 being in_valid & in_ready.
  - d[i] <= d[i-1] (or in_data for i=0) only if the source valid is 1.
  - Otherwise d[i] holds, i.e. data registers are enable-gated and never load bubbles.
- Stalled stage (v[i]=1, r[i+1]=0): v[i] and d[i] hold.
- Bubble collapse: an empty stage accepts from its predecessor even while downstream is stalled. A stalled pipe therefore fills to DEPTH entries.
- Throughput: 1 transfer/cycle sustained when out_ready=1.
- Latency: a word accepted at edge N is presented at out_valid/out_data after edge N+DEPTH-1. It is visible DEPTH-1 cycles after the cycle following acceptance; for DEPTH=1 it is visible the cycle after acceptance.
- Output stability: while out_valid=1 and out_ready=0, out_data is held stable.
- Output transfer: occurs when out_valid & out_ready. This is valid even during a flush cycle; the downstream consumes that word.
- Flush (reset=0, flush=1):
  - in_ready=0, so no input is accepted.
  - At the edge, all v[i] <= 0; data registers hold; occupancy <= 0.
  - Normal operation resumes the cycle after flush deasserts.
- Occupancy: registered count of v[i] after each edge.
  - +1 on an input transfer, -1 on an output transfer, unchanged when both or neither occur.
  - Always equals the popcount of v[]. Never exceeds DEPTH.
- Full (occupancy=DEPTH, out_ready=0): in_ready=0.
- Full with out_ready=1: in_ready=1, allowing simultaneous push and pop with occupancy unchanged.
- Empty: out_valid=0. out_data shows the last held value and must not be relied upon.
- Reset mid-operation: all in-flight words are lost at the reset edge. No transfer completes on that edge from the register-state point of view.

Test Plan:
- Reset and stream, DEPTH=2, WIDTH=8, out_ready=1:
  - Stimulus: after reset, push 0x11,0x22,0x33 on consecutive cycles.
  - Required: out_valid rises the cycle after 0x11 is accepted plus one stage; outputs are 0x11,0x22,0x33 in consecutive cycles; occupancy steady at 2 mid-stream.
  - Required after reset: out_data=RESET_VAL and occupancy=0.
- Backpressure fill, DEPTH=3:
  - Stimulus: out_ready=0, push 0xA1..0xA4 continuously.
  - Required: exactly 3 words accepted, in_ready=0 on the 4th, occupancy=3, out_data=0xA1 stable.
  - Then raise out_ready: 0xA1,0xA2,0xA3 drain in order, one per cycle.
- Bubble collapse, DEPTH=3:
  - Stimulus: push 0x05, idle 2 cycles with out_ready=0, push 0x06.
  - Required: 0x06 accepted, occupancy=2, output order 0x05 then 0x06 once out_ready=1.
- Full push/pop, DEPTH=2:
  - Stimulus: pipe full (0x10,0x20), out_ready=1 and in_valid=1 with 0x30.
  - Required: 0x10 out and 0x30 in on the same edge, occupancy stays 2.
- Flush with output handshake, DEPTH=2:
  - Stimulus: pipe full, flush=1 and out_ready=1 for one cycle, in_valid=1.
  - Required: head word counted as consumed, in_ready=0 in that cycle, occupancy=0 and out_valid=0 after the edge.
  - The next push 0x44 emerges normally.
- Reset mid-stream:
  - Stimulus: reset for 1 cycle while occupancy=2.
  - Required: next cycle out_valid=0, occupancy=0, out_data=RESET_VAL, in_ready=1.

Source files
------------

// File: rtl/lo_pipe_reg.sv
// Elastic register chain: DEPTH valid/ready stages that collapse bubbles and
// apply backpressure per stage. Flush squashes every stage in one cycle.
module lo_pipe_reg #(
  parameter int                 WIDTH     = 32,
  parameter int                 DEPTH     = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH-1:0] r;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             push;
  logic             pop;

  // Stage i can load whenever some stage from i to the tail is empty or the
  // sink is ready; written flat so the ready path has no self-referencing chain.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      assign r[gi] = out_ready | ~(&v_q[DEPTH-1:gi]);

      if (gi == 0) begin : g_head
        assign src_v[gi] = push;
        assign src_d[gi] = in_data;
      end else begin : g_body
        assign src_v[gi] = v_q[gi-1];
        assign src_d[gi] = d_q[gi-1];
      end

      assign v_d[gi] = r[gi] ? src_v[gi] : v_q[gi];
      assign d_d[gi] = (r[gi] & src_v[gi]) ? src_d[gi] : d_q[gi];
    end
  endgenerate

  assign in_ready  = r[0] & ~flush;
  assign push      = in_valid & in_ready;
  assign pop       = v_q[DEPTH-1] & out_ready;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_q;

  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!push && pop) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Data registers never load bubbles and keep their contents across a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= RESET_VAL;
      end
    end else if (flush) begin
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

endmodule
